// File: rtl/butterfly_pipe.sv
// butterfly_pipe: pipelined radix-2 DIT butterfly, C1 = A + W*B, C2 = A - W*B.
// Three register stages under one global enable, with scaling/saturation and a sticky overflow flag.
module butterfly_pipe #(
   parameter int DW = 12,
   parameter int TW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2*DW-1:0] in_a,
   input  logic [2*DW-1:0] in_b,
   input  logic [2*TW-1:0] in_w,
   input  logic          scale_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2*DW-1:0] out_c1,
   output logic [2*DW-1:0] out_c2,
   output logic          ovf,
   input  logic          ovf_clr
);
   localparam int PW = DW + TW + 1;
   localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (TW - 2);
   localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

   function automatic logic [PW-1:0] smul(input logic [DW-1:0] b,
                                          input logic [TW-1:0] w);
      logic signed [PW-1:0] be;
      logic signed [PW-1:0] we;
      be = {{(PW-DW){b[DW-1]}}, b};
      we = {{(PW-TW){w[TW-1]}}, w};
      return be * we;
   endfunction

   // product overflows DW when the bits above the DW sign bit disagree
   function automatic logic p_ovf(input logic [PW-1:0] x);
      return !((&x[PW-1:DW-1]) || !(|x[PW-1:DW-1]));
   endfunction

   function automatic logic [DW-1:0] p_sat(input logic [PW-1:0] x);
      if (p_ovf(x)) return x[PW-1] ? MINV : MAXV;
      return x[DW-1:0];
   endfunction

   function automatic logic s_ovf(input logic [DW:0] x);
      return x[DW] ^ x[DW-1];
   endfunction

   function automatic logic [DW-1:0] s_sat(input logic [DW:0] x);
      if (s_ovf(x)) return x[DW] ? MINV : MAXV;
      return x[DW-1:0];
   endfunction

   logic            en;
   logic            v1_q, v1_d, sc1_q, sc1_d;
   logic [2*DW-1:0] a1_q, a1_d, b1_q, b1_d;
   logic [2*TW-1:0] w1_q, w1_d;
   logic            v2_q, v2_d, sc2_q, sc2_d;
   logic [2*DW-1:0] a2_q, a2_d, p2_q, p2_d;
   logic            v3_q, v3_d;
   logic [2*DW-1:0] c1_q, c1_d, c2_q, c2_d;
   logic            ovf_q, ovf_d;

   logic signed [PW-1:0] pr, pi, pr_sh, pi_sh;
   logic [2*DW-1:0] p_n, c1_n, c2_n;
   logic            sat2, sat3;
   logic [DW:0]     ar, ai, qr, qi, s1r, s1i, s2r, s2i;

   assign en        = !v3_q || out_ready;
   assign in_ready  = en;
   assign out_valid = v3_q;
   assign out_c1    = c1_q;
   assign out_c2    = c2_q;
   assign ovf       = ovf_q;

   // S2 datapath: full-precision complex product, round half-up, saturate
   always_comb begin
      pr = smul(b1_q[2*DW-1:DW], w1_q[2*TW-1:TW])
         - smul(b1_q[DW-1:0], w1_q[TW-1:0]) + RND;
      pi = smul(b1_q[2*DW-1:DW], w1_q[TW-1:0])
         + smul(b1_q[DW-1:0], w1_q[2*TW-1:TW]) + RND;
      pr_sh = pr >>> (TW - 1);
      pi_sh = pi >>> (TW - 1);
      p_n   = {p_sat(pr_sh), p_sat(pi_sh)};
      sat2  = p_ovf(pr_sh) || p_ovf(pi_sh);
   end

   // S3 datapath: DW+1 bit sums, then floor-halve or saturate per transaction
   always_comb begin
      ar  = {a2_q[2*DW-1], a2_q[2*DW-1:DW]};
      ai  = {a2_q[DW-1], a2_q[DW-1:0]};
      qr  = {p2_q[2*DW-1], p2_q[2*DW-1:DW]};
      qi  = {p2_q[DW-1], p2_q[DW-1:0]};
      s1r = ar + qr;
      s1i = ai + qi;
      s2r = ar - qr;
      s2i = ai - qi;
      if (sc2_q) begin
         c1_n = {s1r[DW:1], s1i[DW:1]};
         c2_n = {s2r[DW:1], s2i[DW:1]};
         sat3 = 1'b0;
      end else begin
         c1_n = {s_sat(s1r), s_sat(s1i)};
         c2_n = {s_sat(s2r), s_sat(s2i)};
         sat3 = s_ovf(s1r) || s_ovf(s1i) || s_ovf(s2r) || s_ovf(s2i);
      end
   end

   // next state: every stage advances together on en; ovf set beats clear
   always_comb begin
      v1_d  = v1_q;  a1_d = a1_q; b1_d = b1_q; w1_d = w1_q; sc1_d = sc1_q;
      v2_d  = v2_q;  a2_d = a2_q; p2_d = p2_q; sc2_d = sc2_q;
      v3_d  = v3_q;  c1_d = c1_q; c2_d = c2_q;
      ovf_d = ovf_q;
      if (en) begin
         v1_d  = in_valid;
         a1_d  = in_a;
         b1_d  = in_b;
         w1_d  = in_w;
         sc1_d = scale_en;
         v2_d  = v1_q;
         a2_d  = a1_q;
         p2_d  = p_n;
         sc2_d = sc1_q;
         v3_d  = v2_q;
         c1_d  = c1_n;
         c2_d  = c2_n;
      end
      if (ovf_clr) ovf_d = 1'b0;
      if (en && ((v1_q && sat2) || (v2_q && sat3))) ovf_d = 1'b1;
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0; a1_q <= '0; b1_q <= '0; w1_q <= '0; sc1_q <= 1'b0;
         v2_q <= 1'b0; a2_q <= '0; p2_q <= '0; sc2_q <= 1'b0;
         v3_q <= 1'b0; c1_q <= '0; c2_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         v1_q <= v1_d; a1_q <= a1_d; b1_q <= b1_d; w1_q <= w1_d; sc1_q <= sc1_d;
         v2_q <= v2_d; a2_q <= a2_d; p2_q <= p2_d; sc2_q <= sc2_d;
         v3_q <= v3_d; c1_q <= c1_d; c2_q <= c2_d;
         ovf_q <= ovf_d;
      end
   end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed and randomised checks of butterfly_pipe
// against hand-computed values and an integer reference model.
module tb_butterfly_pipe;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, scale_en;
   logic        out_valid, out_ready, ovf, ovf_clr;
   logic [23:0] in_a, in_b, in_w, out_c1, out_c2;
   int          n_chk = 0;
   int          n_fail = 0;

   butterfly_pipe #(.DW(12), .TW(12)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_w(in_w), .scale_en(scale_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_c1(out_c1), .out_c2(out_c2),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [23:0] cx(input int re, input int im);
      return {12'(re), 12'(im)};
   endfunction

   function automatic int clamp(input int x, output bit s);
      s = 1'b0;
      if (x > 2047) begin s = 1'b1; return 2047; end
      if (x < -2048) begin s = 1'b1; return -2048; end
      return x;
   endfunction

   task automatic model(input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] w, input bit sc,
                        output logic [23:0] c1, output logic [23:0] c2,
                        output bit sat);
      int ar, ai, br, bi, wr, wi, pr, pi, s1r, s1i, s2r, s2i;
      bit f0, f1, f2, f3, f4, f5;
      ar = $signed(a[23:12]); ai = $signed(a[11:0]);
      br = $signed(b[23:12]); bi = $signed(b[11:0]);
      wr = $signed(w[23:12]); wi = $signed(w[11:0]);
      pr = (br * wr - bi * wi + 1024) >>> 11;
      pi = (br * wi + bi * wr + 1024) >>> 11;
      pr = clamp(pr, f0);
      pi = clamp(pi, f1);
      s1r = ar + pr; s1i = ai + pi;
      s2r = ar - pr; s2i = ai - pi;
      f2 = 0; f3 = 0; f4 = 0; f5 = 0;
      if (sc) begin
         s1r = s1r >>> 1; s1i = s1i >>> 1;
         s2r = s2r >>> 1; s2i = s2i >>> 1;
      end else begin
         s1r = clamp(s1r, f2); s1i = clamp(s1i, f3);
         s2r = clamp(s2r, f4); s2i = clamp(s2i, f5);
      end
      c1 = cx(s1r, s1i);
      c2 = cx(s2r, s2i);
      sat = f0 | f1 | f2 | f3 | f4 | f5;
   endtask

   task automatic drive_one(input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] w, input bit sc);
      @(negedge clk);
      in_a = a; in_b = b; in_w = w; scale_en = sc; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({out_valid, ovf, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_flags: got v/ovf/rdy=%b want 001", {out_valid, ovf, in_ready});
      end
      n_chk++;
      if ({out_c1, out_c2} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h want 0/0", out_c1, out_c2);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      drive_one(cx(100, -50), cx(20, 30), cx(-2048, 0), 1'b1);
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) @(negedge clk);
         n_chk++;
         if (out_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL basic_latency: cycle %0d got valid %b want %b", i, out_valid, i == 3);
         end
      end
      n_chk++;
      if (out_c1 !== cx(40, -40) || out_c2 !== cx(60, -10) || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_data: got %h/%h ovf %b want %h/%h ovf 0",
                  out_c1, out_c2, ovf, cx(40, -40), cx(60, -10));
      end
   endtask

   task automatic test_saturation();
      drive_one(cx(2000, 0), cx(-2000, 0), cx(-2048, 0), 1'b0);
      repeat (2) @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || out_c1 !== cx(2047, 0) || out_c2 !== cx(0, 0)) begin
         n_fail++;
         $display("FAIL sat_data: got v%b %h/%h want v1 %h/%h",
                  out_valid, out_c1, out_c2, cx(2047, 0), cx(0, 0));
      end
      n_chk++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_ovf: got %b want 1", ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      n_chk++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_ovf_clr: got %b want 0", ovf);
      end
   endtask

   task automatic test_rounding();
      logic [23:0] bv [3];
      logic [23:0] wv [3];
      logic [23:0] e1 [3];
      logic [23:0] e2 [3];
      logic        eo [3];
      bv = '{cx(3, 0), cx(-3, 0), cx(-2048, 0)};
      wv = '{cx(1024, 0), cx(1024, 0), cx(-2048, 0)};
      e1 = '{cx(2, 0), cx(-1, 0), cx(2047, 0)};
      e2 = '{cx(-2, 0), cx(1, 0), cx(-2047, 0)};
      eo = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive_one(24'h0, bv[i], wv[i], 1'b0);
         repeat (2) @(negedge clk);
         n_chk++;
         if (out_c1 !== e1[i] || out_c2 !== e2[i] || ovf !== eo[i]) begin
            n_fail++;
            $display("FAIL round_%0d: got %h/%h ovf %b want %h/%h ovf %b",
                     i, out_c1, out_c2, ovf, e1[i], e2[i], eo[i]);
         end
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
   endtask

   task automatic run_stream(input int n, input bit rand_rdy, input string tag);
      logic [23:0] q1 [$];
      logic [23:0] q2 [$];
      logic [23:0] va, vb, vw, h1, h2, m1, m2;
      bit vs, have, stalled, any_sat, s;
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      have = 0; stalled = 0; any_sat = 0;
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      while (got < n && cyc < 500) begin
         if (!have && sent < n) begin
            va = 24'($urandom); vb = 24'($urandom);
            vw = 24'($urandom); vs = 1'($urandom);
            have = 1;
         end
         in_valid = have;
         in_a = va; in_b = vb; in_w = vw; scale_en = vs;
         out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc < 8);
         #1;
         if (stalled) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_c1 !== h1 || out_c2 !== h2) begin
               n_fail++;
               $display("FAIL %s_hold: got v%b %h/%h want v1 %h/%h",
                        tag, out_valid, out_c1, out_c2, h1, h2);
            end
         end
         if (out_valid && !out_ready) begin
            n_chk++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL %s_in_ready: got %b want 0 while stalled", tag, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            n_chk++;
            if (q1.size() == 0) begin
               n_fail++;
               $display("FAIL %s_extra: got %h/%h want no output", tag, out_c1, out_c2);
            end else begin
               m1 = q1.pop_front();
               m2 = q2.pop_front();
               if (out_c1 !== m1 || out_c2 !== m2) begin
                  n_fail++;
                  $display("FAIL %s_data[%0d]: got %h/%h want %h/%h",
                           tag, got, out_c1, out_c2, m1, m2);
               end
            end
            got++;
         end
         stalled = out_valid && !out_ready;
         h1 = out_c1;
         h2 = out_c2;
         if (in_valid && in_ready) begin
            model(va, vb, vw, vs, m1, m2, s);
            q1.push_back(m1);
            q2.push_back(m2);
            any_sat |= s;
            sent++;
            have = 0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_chk++;
      if (got != n) begin
         n_fail++;
         $display("FAIL %s_count: got %0d outputs want %0d", tag, got, n);
      end
      n_chk++;
      if (ovf !== any_sat) begin
         n_fail++;
         $display("FAIL %s_ovf: got %b want %b", tag, ovf, any_sat);
      end
      repeat (4) @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: got valid %b want 0", tag, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      run_stream(8, 1'b0, "bp");
   endtask

   task automatic test_reset_midstream();
      drive_one(cx(2000, 0), cx(-2000, 0), cx(-2048, 0), 1'b0);
      repeat (2) @(negedge clk);
      n_chk++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL rstm_pre_ovf: got %b want 1", ovf);
      end
      in_a = cx(5, 5); in_b = cx(7, 7); in_w = cx(1024, 0);
      scale_en = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_a = cx(9, 9);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || ovf !== 1'b0 || {out_c1, out_c2} !== 48'h0) begin
         n_fail++;
         $display("FAIL rstm_clear: got v%b ovf%b %h/%h want v0 ovf0 0/0",
                  out_valid, ovf, out_c1, out_c2);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstm_stale: cycle %0d got valid %b want 0", i, out_valid);
         end
      end
      drive_one(cx(100, -50), cx(20, 30), cx(-2048, 0), 1'b1);
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) @(negedge clk);
         n_chk++;
         if (out_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL rstm_latency: cycle %0d got valid %b want %b", i, out_valid, i == 3);
         end
      end
      n_chk++;
      if (out_c1 !== cx(40, -40) || out_c2 !== cx(60, -10)) begin
         n_fail++;
         $display("FAIL rstm_data: got %h/%h want %h/%h",
                  out_c1, out_c2, cx(40, -40), cx(60, -10));
      end
   endtask

   task automatic test_ovf_set_wins();
      drive_one(cx(2000, 0), cx(-2000, 0), cx(-2048, 0), 1'b0);
      @(negedge clk);
      n_chk++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL setwins_pre: got ovf %b want 0", ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      n_chk++;
      if (ovf !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL setwins: got ovf %b valid %b want 1 1", ovf, out_valid);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      n_chk++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL setwins_clr: got ovf %b want 0", ovf);
      end
   endtask

   task automatic test_random();
      run_stream(60, 1'b1, "rand");
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      scale_en = 1'b0; in_a = '0; in_b = '0; in_w = '0;
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_reset_midstream();
      test_ovf_set_wins();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
